// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default payload width and
// the minimum usable clk_div.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [31:0] MIN_CLK_DIV = 32'd2;

    // 4-bit encodings so receiver and transmitter share one state width.
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_DATA  = 4'd2;
    localparam logic [3:0] ST_STOP  = 4'd3;
    localparam logic [3:0] ST_DONE  = 4'd4;

    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div < MIN_CLK_DIV) ? MIN_CLK_DIV : div;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so no false start bit is seen after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start-bit qualification at half a bit period, mid-bit data
// sampling, LSB first, with held valid/frame-error/overrun flags.
module uart_receive
    import uart_pkg::*;
#(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          clk_div,
    input  logic                 rx,
    input  logic                 rx_clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    logic                 rx_s;
    logic                 rx_prev_reg;
    logic [3:0]           state_reg;
    logic [31:0]          clk_cnt_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_sample_reg;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 frame_err_reg;
    logic                 overrun_err_reg;
    logic                 busy_reg;

    logic [31:0] div_eff;
    logic [31:0] half_lim;
    logic [31:0] bit_lim;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign div_eff  = eff_div(clk_div);
    assign bit_lim  = div_eff - 32'd1;
    assign half_lim = (div_eff >> 1) - 32'd1;

    // Compares use >= so a clk_div reduced mid-frame ends the period at once
    // instead of letting the counter run on towards a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_reg     <= 1'b1;
            state_reg       <= ST_IDLE;
            clk_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            stop_sample_reg <= 1'b0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            rx_prev_reg <= rx_s;

            if (rx_clear) begin
                rx_valid_reg    <= 1'b0;
                frame_err_reg   <= 1'b0;
                overrun_err_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (rx_prev_reg && !rx_s) begin
                        state_reg   <= ST_START;
                        clk_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                ST_START: begin
                    if (clk_cnt_reg >= half_lim) begin
                        clk_cnt_reg <= '0;
                        if (!rx_s) begin
                            state_reg <= ST_DATA;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_reg >= bit_lim) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                            state_reg <= ST_STOP;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt_reg >= bit_lim) begin
                        clk_cnt_reg     <= '0;
                        stop_sample_reg <= rx_s;
                        state_reg       <= ST_DONE;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 32'd1;
                    end
                end
                ST_DONE: begin
                    // A completing byte overrides a coincident rx_clear.
                    rx_data_reg     <= shift_reg;
                    rx_valid_reg    <= 1'b1;
                    frame_err_reg   <= !stop_sample_reg;
                    overrun_err_reg <= rx_clear ? 1'b0 : (overrun_err_reg | rx_valid_reg);
                    busy_reg        <= 1'b0;
                    state_reg       <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_err_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_receive.sv
// Directed plus randomized frames against a frame-level reference model of
// the receiver's flags, data and rx_valid timing.
module tb_uart_receive;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        rx_clear = 1'b0;
    logic [31:0] clk_div = 32'd4;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   rise_cycle = -1;
    logic valid_d = 1'b0;
    bit   busy_seen = 1'b0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;
    int         exp_rise = -1;

    uart_receive dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_div     (clk_div),
        .rx          (rx),
        .rx_clear    (rx_clear),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_d) rise_cycle <= cyc;
        valid_d <= rx_valid;
        if (busy) busy_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"}, rx_data, exp_data);
        check({tag, "_valid"}, rx_valid, exp_valid);
        check({tag, "_ferr"}, frame_err, exp_ferr);
        check({tag, "_ovr"}, overrun_err, exp_ovr);
        check({tag, "_busy"}, busy, 1'b0);
        $display("txn %s: data=0x%02h valid=%0b ferr=%0b ovr=%0b", tag, rx_data, rx_valid, frame_err, overrun_err);
    endtask

    task automatic clear_flags();
        @(posedge clk);
        #1;
        rx_clear = 1'b1;
        @(posedge clk);
        #1;
        rx_clear = 1'b0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // Frame k starts when rx falls just after edge k. Two sync flops plus the
    // edge detector confirm the start bit after edge k+3+half, the stop bit
    // is sampled nine bit periods later, and rx_valid follows one edge after.
    task automatic send(input logic [7:0] d, input logic stop, input int div,
                        input bit clr_done, input bit hold_low);
        logic [9:0] fr;
        int eff;
        int half;
        int n;
        int k;
        fr   = {stop, d, 1'b0};
        eff  = (div < 2) ? 2 : div;
        half = eff / 2;
        n    = 11 * eff + 8;
        clk_div    = div;
        rise_cycle = -1;
        @(posedge clk);
        #1;
        k  = cyc;
        rx = 1'b0;
        for (int c = 1; c < n; c++) begin
            @(posedge clk);
            #1;
            rx       = (c < 10 * eff) ? fr[c / eff] : !hold_low;
            rx_clear = clr_done && (cyc == k + 3 + half + 9 * eff);
            if (cyc == k + 4 + half) check("busy_in_frame", busy, 1'b1);
        end
        rx_clear = 1'b0;
        exp_rise  = exp_valid ? -1 : (k + 4 + half + 9 * eff);
        exp_ovr   = clr_done ? 1'b0 : (exp_ovr | exp_valid);
        exp_valid = 1'b1;
        exp_data  = d;
        exp_ferr  = !stop;
        check("rise_cycle", rise_cycle, exp_rise);
        check_outputs($sformatf("frame_%02h_div%0d", d, div));
    endtask

    initial begin
        logic [9:0] fr;
        int k;

        // Reset state
        tick(3);
        exp_data = 8'h00;
        check_outputs("reset");
        rst_n = 1'b1;
        tick(5);

        // Basic frame, stop bit good
        send(8'h5A, 1'b1, 4, 1'b0, 1'b0);
        clear_flags();
        check_outputs("clear_after_5a");

        // One-cycle glitch is rejected
        clk_div    = 32'd8;
        busy_seen  = 1'b0;
        rise_cycle = -1;
        @(posedge clk);
        #1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        tick(40);
        check("glitch_busy_seen", busy_seen, 1'b0);
        check("glitch_rise", rise_cycle, -1);
        check_outputs("glitch");

        // Frame error, line held low, then recovery
        send(8'hA5, 1'b0, 4, 1'b0, 1'b1);
        busy_seen  = 1'b0;
        rise_cycle = -1;
        tick(40);
        check("low_hold_busy_seen", busy_seen, 1'b0);
        check_outputs("low_hold");
        rx = 1'b1;
        tick(10);
        clear_flags();
        send(8'h3C, 1'b1, 4, 1'b0, 1'b0);

        // Overrun
        clear_flags();
        send(8'h11, 1'b1, 4, 1'b0, 1'b0);
        send(8'h22, 1'b1, 6, 1'b0, 1'b0);
        clear_flags();
        check_outputs("clear_after_overrun");

        // rx_clear coinciding with the DONE cycle
        send(8'h55, 1'b1, 5, 1'b0, 1'b0);
        send(8'h7E, 1'b1, 4, 1'b1, 1'b0);

        // clk_div below the minimum behaves as 2
        clear_flags();
        send(8'h96, 1'b1, 0, 1'b0, 1'b0);

        // Reset during data bit 3
        clear_flags();
        clk_div = 32'd4;
        fr = {1'b1, 8'hFF, 1'b0};
        @(posedge clk);
        #1;
        k  = cyc;
        rx = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            rx = fr[c / 4];
        end
        check("pre_reset_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        check_outputs("async_reset");
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        rise_cycle = -1;
        tick(80);
        check("post_reset_rise", rise_cycle, -1);
        check_outputs("post_reset");
        send(8'hC3, 1'b1, 4, 1'b0, 1'b0);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic       stop;
            int         div;
            bit         clr;
            d    = 8'($urandom);
            stop = ($urandom % 4) != 0;
            div  = int'($urandom_range(3, 12));
            clr  = ($urandom % 3) == 0;
            if ($urandom % 2) clear_flags();
            send(d, stop, div, clr, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter: DATA_BITS, default 8, payload bits per frame.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: clk_div  input  32  clk cycles per bit; values below 2 are treated as 2.
REQ-005 Port: rx  input  1  serial line, asynchronous, idles high.
REQ-006 Port: rx_clear  input  1  single-cycle consumer acknowledge.
REQ-007 Port: rx_data  output  8  last received byte, LSB first on the line.
REQ-008 Port: rx_valid  output  1  byte available; held until cleared.
REQ-009 Port: frame_err  output  1  stop bit was sampled low for the held byte.
REQ-010 Port: overrun_err  output  1  a byte completed while rx_valid was already 1.
REQ-011 Port: busy  output  1  high from start-bit confirmation through the stop-bit sample.

Function
REQ-012 The block SHALL pass rx through a 2-FF synchronizer; all logic below uses the synchronized value (rx_s) and its previous value.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0) -> START, with bit counter = 0 and clk_cnt = 0.
REQ-015 START: count to (clk_div>>1)-1; at that count, rx_s==0 -> DATA with clk_cnt=0 and busy=1; rx_s==1 -> IDLE (glitch rejected, no outputs change).
REQ-016 DATA: count to clk_div-1; at that count, sample rx_s into shift bit[idx], idx+1, clk_cnt=0; after idx==7 -> STOP.
REQ-017 STOP: count to clk_div-1; at that count, sample rx_s -> DONE.
REQ-018 DONE (one cycle): load rx_data from the shift register; rx_valid=1; frame_err = !stop_sample; overrun_err |= old rx_valid; busy=0; -> IDLE.
REQ-019 rx_valid SHALL assert exactly 1 cycle after the stop-sample cycle.
REQ-020 rx_clear SHALL clear rx_valid, frame_err and overrun_err on the next edge.
REQ-021 If rx_clear and DONE coincide, DONE wins: rx_valid=1, the new data is loaded, and overrun_err is not set by that byte.
REQ-022 On overrun, the new byte SHALL overwrite rx_data.
REQ-023 After a frame error with rx held low, IDLE SHALL NOT restart until rx_s has returned high and falls again.
REQ-024 A clk_div change mid-frame takes effect at the next counter compare; it is not otherwise guarded.
REQ-025 Counter compares SHALL be full 32-bit; clk_cnt SHALL never wrap.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0, counters=0, synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abandon the frame; no rx_valid for that byte after release.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encodings (4-bit, matching the transmitter's width), DATA_BITS, and the minimum clk_div constant.
REQ-029 One sub-module uart_rx_sync (2-FF synchronizer, reset value 1) SHALL be instantiated; the remaining logic stays flat.

Verification
REQ-030 clk_div=4, frame 0x5A with stop=1 -> rx_data=0x5A, rx_valid=1, frame_err=0, rx_valid rising 1 cycle after the stop sample.
REQ-031 clk_div=8, 1-cycle low glitch on rx -> returns to IDLE, busy never 1, rx_valid stays 0.
REQ-032 clk_div=4, frame 0xA5 with stop=0 -> rx_data=0xA5, frame_err=1; rx held low, then high, then frame 0x3C -> 0x3C received.
REQ-033 Two frames 0x11 then 0x22, no rx_clear -> rx_data=0x22, overrun_err=1; rx_clear -> all three flags 0.
REQ-034 rx_clear pulsed in the DONE cycle of frame 0x7E -> rx_valid=1, overrun_err=0, rx_data=0x7E.
REQ-035 rst_n low during DATA bit 3 of 0xFF, released with rx high -> outputs 0, no rx_valid until the next full frame.
